// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD constants and the nibble-validity helper used by
//                the load check of the multi-digit decimal counter.
//  Contents    : BCD_W   - width of one decimal digit
//                BCD_MAX - largest legal digit value (9)
//                BCD_MIN - smallest legal digit value (0)
//                is_bcd  - 1 when a nibble holds a legal decimal digit
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One decade stage of the BCD counter. Holds a single digit,
//                steps it up or down with decimal wrap (9<->0) and flags when
//                it sits at 9 or 0 so the top level can build ripple enables.
//  Ports       : clk, rst_n    - clock, synchronous active-low reset
//                i_step        - advance this digit by one in direction i_up
//                i_up          - 1 = increment, 0 = decrement
//                i_load        - load i_load_val (validated by the top level)
//                i_load_val    - digit value to load
//                i_rst_val     - digit value applied during reset
//                o_digit       - registered digit value
//                o_at_max      - digit currently equals 9 (combinational)
//                o_at_min      - digit currently equals 0 (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_step,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    input  logic [BCD_W-1:0] i_rst_val,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_at_max,
    output logic             o_at_min
);

    logic [BCD_W-1:0] r_digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit <= i_rst_val;
        end else if (i_load) begin
            r_digit <= i_load_val;
        end else if (i_step) begin
            if (i_up) begin
                r_digit <= (r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
            end
        end
    end

    assign o_digit  = r_digit;
    assign o_at_max = (r_digit == BCD_MAX);
    assign o_at_min = (r_digit == BCD_MIN);

endmodule
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter
//  Description : Parametrised multi-digit BCD up/down counter with enable,
//                parallel load (rejecting non-decimal nibbles), optional
//                saturation and a one-cycle terminal-count pulse. o_carry can
//                drive i_en of a following stage to build wider counters.
//  Ports       : clk, rst_n    - clock, synchronous active-low reset
//                i_en          - count step request
//                i_up          - 1 = increment, 0 = decrement
//                i_load        - parallel load strobe (has priority over i_en)
//                i_load_val    - packed BCD load value, digit k in [4k+3:4k]
//                o_cnt         - packed BCD count (registered)
//                o_carry       - step taken at terminal value (registered)
//                o_load_err    - load rejected, bad nibble (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter #(
    parameter int                    DIGITS   = 2,
    parameter bit                    SATURATE = 1'b0,
    parameter logic [4*DIGITS-1:0]   RST_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_up,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_val,
    output logic [4*DIGITS-1:0]   o_cnt,
    output logic                  o_carry,
    output logic                  o_load_err
);

    import bcd_pkg::*;

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_min;
    logic [DIGITS-1:0] w_digit_step;
    // Bit k of each chain is 1 when every digit below k is at 9 (or 0);
    // the top bit therefore marks the terminal value of the whole counter.
    logic [DIGITS:0]   w_max_chain;
    logic [DIGITS:0]   w_min_chain;
    logic              w_load_valid;
    logic              w_load_ok;
    logic              w_count;
    logic              w_terminal;
    logic              w_advance;
    logic              r_carry;
    logic              r_load_err;

    always_comb begin
        w_max_chain    = '0;
        w_min_chain    = '0;
        w_load_valid   = 1'b1;
        w_max_chain[0] = 1'b1;
        w_min_chain[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            w_max_chain[k+1] = w_max_chain[k] & w_at_max[k];
            w_min_chain[k+1] = w_min_chain[k] & w_at_min[k];
            w_load_valid     = w_load_valid & is_bcd(i_load_val[k*BCD_W +: BCD_W]);
        end
    end

    assign w_load_ok  = i_load & w_load_valid;
    assign w_count    = i_en & ~i_load;
    assign w_terminal = i_up ? w_max_chain[DIGITS] : w_min_chain[DIGITS];
    // In saturating mode a step at the terminal value is swallowed entirely;
    // otherwise every digit steps and wraps, which yields all-0 / all-9.
    assign w_advance  = w_count & ~(SATURATE & w_terminal);

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digits
            assign w_digit_step[k] = w_advance & (i_up ? w_max_chain[k] : w_min_chain[k]);

            bcd_digit u_digit (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_step     (w_digit_step[k]),
                .i_up       (i_up),
                .i_load     (w_load_ok),
                .i_load_val (i_load_val[k*BCD_W +: BCD_W]),
                .i_rst_val  (RST_VAL[k*BCD_W +: BCD_W]),
                .o_digit    (o_cnt[k*BCD_W +: BCD_W]),
                .o_at_max   (w_at_max[k]),
                .o_at_min   (w_at_min[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_carry    <= w_count & w_terminal;
            r_load_err <= i_load & ~w_load_valid;
        end
    end

    assign o_carry    = r_carry;
    assign o_load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_counter
//  Description : Self-checking bench for bcd_counter. Two 2-digit instances
//                share one stimulus stream: A wraps (reset value 00), B
//                saturates (reset value 25). Each is compared every cycle
//                against a decimal-integer model, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter;

    localparam int c_MAXV = 99;

    logic       clk;
    logic       rst_n;
    logic       i_en;
    logic       i_up;
    logic       i_load;
    logic [7:0] i_load_val;
    logic [7:0] cnt_a, cnt_b;
    logic       carry_a, carry_b, err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    // model state (decimal integers)
    int m_a, m_b;
    bit m_carry, m_err, m_valid;

    bcd_counter #(.DIGITS(2), .SATURATE(1'b0), .RST_VAL(8'h00)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_up(i_up), .i_load(i_load),
        .i_load_val(i_load_val), .o_cnt(cnt_a), .o_carry(carry_a), .o_load_err(err_a));

    bcd_counter #(.DIGITS(2), .SATURATE(1'b1), .RST_VAL(8'h25)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_up(i_up), .i_load(i_load),
        .i_load_val(i_load_val), .o_cnt(cnt_b), .o_carry(carry_b), .o_load_err(err_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit valid_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit is_term(input int v, input bit up);
        return up ? (v == c_MAXV) : (v == 0);
    endfunction

    function automatic int next_val(input int v, input bit up, input bit sat);
        if (is_term(v, up)) return sat ? v : (up ? 0 : c_MAXV);
        return up ? v + 1 : v - 1;
    endfunction

    // Reference model: one decimal step per accepted request.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_a <= 0; m_b <= 25; m_carry <= 1'b0; m_err <= 1'b0; m_valid <= 1'b1;
        end else if (i_load) begin
            if (valid_bcd(i_load_val)) begin
                m_a <= from_bcd(i_load_val);
                m_b <= from_bcd(i_load_val);
            end
            m_carry <= 1'b0;
            m_err   <= !valid_bcd(i_load_val);
        end else if (i_en) begin
            // A and B share stimulus; carry depends only on the common value
            // while they agree, so each carry is checked against its own model.
            m_a     <= next_val(m_a, i_up, 1'b0);
            m_b     <= next_val(m_b, i_up, 1'b1);
            m_carry <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_carry <= 1'b0;
            m_err   <= 1'b0;
        end
    end

    // Per-instance carry model (a term seen on the stepping edge).
    bit m_carry_a, m_carry_b;
    always @(posedge clk) begin
        if (!rst_n || i_load || !i_en) begin
            m_carry_a <= 1'b0;
            m_carry_b <= 1'b0;
        end else begin
            m_carry_a <= is_term(m_a, i_up);
            m_carry_b <= is_term(m_b, i_up);
        end
    end

    // Every-cycle comparison once the first reset edge has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("a_cnt",     32'(cnt_a),   32'(to_bcd(m_a)));
            chk("b_cnt",     32'(cnt_b),   32'(to_bcd(m_b)));
            chk("a_carry",   32'(carry_a), 32'(m_carry_a));
            chk("b_carry",   32'(carry_b), 32'(m_carry_b));
            chk("a_err",     32'(err_a),   32'(m_err));
            chk("b_err",     32'(err_b),   32'(m_err));
            chk("a_nibbles", 32'(valid_bcd(cnt_a)), 32'd1);
            chk("b_nibbles", 32'(valid_bcd(cnt_b)), 32'd1);
        end
    end

    task automatic cyc(input bit rn, input bit en, input bit up, input bit ld, input logic [7:0] val);
        rst_n = rn; i_en = en; i_up = up; i_load = ld; i_load_val = val;
        @(posedge clk);
        @(negedge clk);
    endtask

    int carries_a;

    initial begin
        rst_n = 1'b0; i_en = 1'b1; i_up = 1'b1; i_load = 1'b0; i_load_val = 8'h00;

        // 1. reset hold with enable high
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            chk("rst_cnt_a", 32'(cnt_a), 32'h00);
            chk("rst_cnt_b", 32'(cnt_b), 32'h25);
            chk("rst_carry", 32'(carry_a), 32'd0);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("first_step", 32'(cnt_a), 32'h01);

        // 2. up wrap: from 00, 100 steps, exactly one carry when 00 reappears
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        carries_a = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            if (carry_a) carries_a++;
            if (i == 10)  chk("up_10", 32'(cnt_a), 32'h10);
            if (i == 99)  chk("up_99", 32'(cnt_a), 32'h99);
            if (i == 100) begin
                chk("up_wrap", 32'(cnt_a), 32'h00);
                chk("up_wrap_carry", 32'(carry_a), 32'd1);
            end
        end
        chk("up_carry_count", 32'(carries_a), 32'd1);

        // 3. down across decade and down wrap
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("down_09", 32'(cnt_a), 32'h09);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("down_08", 32'(cnt_a), 32'h08);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("down_wrap", 32'(cnt_a), 32'h99);
        chk("down_carry", 32'(carry_a), 32'd1);
        chk("down_sat_b", 32'(cnt_b), 32'h00);

        // 4. saturation on B
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h98);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("sat_1", 32'({cnt_b, 3'b0, carry_b}), 32'h990);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("sat_2", 32'({cnt_b, 3'b0, carry_b}), 32'h991);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("sat_3", 32'({cnt_b, 3'b0, carry_b}), 32'h991);

        // 5. load priority over enable; invalid load rejected
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h45);
        chk("load_45", 32'(cnt_a), 32'h45);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h4A);
        chk("bad_load_cnt", 32'(cnt_a), 32'h45);
        chk("bad_load_err", 32'(err_a), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("err_pulse_end", 32'(err_a), 32'd0);

        // 6. mid-count reset, then resume from reset value
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h36);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("mid_37", 32'(cnt_a), 32'h37);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("mid_rst_a", 32'(cnt_a), 32'h00);
        chk("mid_rst_b", 32'(cnt_b), 32'h25);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("resume_a", 32'(cnt_a), 32'h01);
        chk("resume_b", 32'(cnt_b), 32'h26);

        // Randomised run, biased toward the terminal values.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] v;
            bit rn, en, up, ld;
            case ($urandom_range(0, 5))
                0:       v = 8'($urandom);
                1:       v = 8'h99;
                2:       v = 8'h00;
                3:       v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 15))};
                default: v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            endcase
            rn = ($urandom_range(0, 63) != 0);
            en = ($urandom_range(0, 3) != 0);
            up = ($urandom_range(0, 7) < 5);
            ld = ($urandom_range(0, 15) == 0);
            cyc(rn, en, up, ld, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
